apb_arbiter2: RTL and testbench
===============================

# apb_arbiter2

Two-requester APB master arbiter that shares a single APB slave port (such as a register block with an `s_apb_*` interface) between two internal initiators, e.g. a debug/bring-up path and a firmware sequencer. Each requester presents a simple held-valid command. The block picks one round-robin, runs a full APB SETUP/ACCESS transfer, and returns read data and error status with a one-cycle done pulse. A programmable PREADY timeout prevents a hung slave from locking the bus.

## Interface
Parameters:
- G_REGWIDTH, 32, data width; multiple of 8
- G_ADDR_WIDTH, 4, APB address width
- G_TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout

Ports (N ∈ {0,1}, one set per requester):
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  request pending; held high and stable until reqN_done
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  G_ADDR_WIDTH  transfer address
- reqN_wdata  in  G_REGWIDTH  write data
- reqN_strb  in  G_REGWIDTH/8  write byte strobes
- reqN_done  out  1  one-cycle pulse, transfer complete
- reqN_rdata  out  G_REGWIDTH  read data; valid while reqN_done=1
- reqN_err  out  1  PSLVERR or timeout; valid while reqN_done=1
- m_apb_psel  out  1  APB select
- m_apb_penable  out  1  APB enable
- m_apb_pwrite  out  1  APB direction
- m_apb_pprot  out  3  driven constant 3'b000
- m_apb_paddr  out  G_ADDR_WIDTH  APB address
- m_apb_pwdata  out  G_REGWIDTH  APB write data
- m_apb_pstrb  out  G_REGWIDTH/8  APB strobes; forced all-zero on reads
- m_apb_pready  in  1  slave ready
- m_apb_prdata  in  G_REGWIDTH  slave read data
- m_apb_pslverr  in  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- Reset values: state IDLE; psel, penable, pwrite, paddr, pwdata, pstrb all 0; reqN_done=0, reqN_rdata=0, reqN_err=0; last_grant=1, so requester 0 wins the first contention; timeout counter 0.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant that requester.
  - Both valid: grant the requester ≠ last_grant.
  - On grant: latch write/addr/wdata/strb into the APB output registers, record the grant, go to SETUP.
- SETUP: psel=1, penable=0. Next cycle goes to ACCESS with penable=1.
- ACCESS: psel=1, penable=1. Each cycle:
  - pready=1: capture prdata (reads; 0 for writes) and pslverr, go to DONE.
  - pready=0 and G_TIMEOUT≠0 and counter = G_TIMEOUT−1: abort. Capture rdata=0, err=1, go to DONE.
  - Otherwise: increment the counter and stay.
- DONE: psel=0, penable=0. reqN_done=1 for the granted requester only. last_grant ← granted index. Counter cleared. Next state IDLE.
- Non-granted reqN_done is always 0. reqN_rdata/err hold their last values outside done.
- APB address, data and control stay stable from SETUP through the last ACCESS cycle. Requester inputs are not re-sampled after the grant.
- Requester contract: deassert or replace reqN_valid on the edge after sampling done. IDLE then sees the updated value.
- Synchronous rst in any state returns to IDLE on the next edge and drops psel/penable. No done is issued for an aborted transfer.

## Timing
- Valid seen in IDLE at cycle T. SETUP at T+1, ACCESS at T+2.
- Zero-wait slave (pready=1 at T+2): done at T+3, IDLE at T+4. Earliest next SETUP is T+5, giving a 4-cycle throughput per transfer.
- Each pready=0 ACCESS cycle adds one cycle.
- Timeout: with G_TIMEOUT=k, at most k ACCESS cycles, then DONE with err=1.
- A valid arriving during SETUP/ACCESS/DONE waits for IDLE. Arbitration is evaluated only in IDLE.

## Test plan
- Single read, req0 addr 0x4, slave pready=1 immediately, prdata 0xDEADBEEF. Expect: psel at T+1, penable at T+2, req0_done at T+3, req0_rdata=0xDEADBEEF, req0_err=0.
- Write with 3 wait states, req1 addr 0x8, wdata 0x12345678, strb 0xF. Expect: APB signals stable across 4 ACCESS cycles, req1_done 1 cycle after pready, req1_err=0.
- Both valid from reset, each issuing 3 back-to-back requests. Expect grant order 0,1,0,1,0,1, and no done pulse on the non-granted port.
- Slave never asserts pready, G_TIMEOUT=16. Expect exactly 16 ACCESS cycles, then req0_done with err=1, rdata=0, and psel=0.
- pslverr=1 with pready on a read. Expect reqN_err=1 and rdata captured.
- rst asserted during ACCESS. Expect psel/penable=0 next cycle, no done, and the next contention granted to req0.

Source files
------------

// File: rtl/apb_arbiter2.sv
// Two-requester round-robin APB master arbiter with a PREADY timeout.
// One APB transfer at a time; results return on a one-cycle per-requester done pulse.
module apb_arbiter2 #(
  parameter int unsigned G_REGWIDTH   = 32,
  parameter int unsigned G_ADDR_WIDTH = 4,
  parameter int unsigned G_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic                      req0_write,
  input  logic [G_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [G_REGWIDTH-1:0]     req0_wdata,
  input  logic [G_REGWIDTH/8-1:0]   req0_strb,
  output logic                      req0_done,
  output logic [G_REGWIDTH-1:0]     req0_rdata,
  output logic                      req0_err,
  input  logic                      req1_valid,
  input  logic                      req1_write,
  input  logic [G_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [G_REGWIDTH-1:0]     req1_wdata,
  input  logic [G_REGWIDTH/8-1:0]   req1_strb,
  output logic                      req1_done,
  output logic [G_REGWIDTH-1:0]     req1_rdata,
  output logic                      req1_err,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [2:0]                m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
  input  logic                      m_apb_pslverr
);

  localparam int unsigned STRB_W   = G_REGWIDTH / 8;
  localparam int unsigned CNT_W    = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (G_TIMEOUT == 0) ? 0 : G_TIMEOUT - 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic              grant, grant_d;
  logic              last_grant, last_grant_d;
  logic              grant_sel;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              timeout_hit;

  logic                    psel_d, penable_d, pwrite_d;
  logic [G_ADDR_WIDTH-1:0] paddr_d;
  logic [G_REGWIDTH-1:0]   pwdata_d;
  logic [STRB_W-1:0]       pstrb_d;
  logic                    done0_d, done1_d, err0_d, err1_d;
  logic [G_REGWIDTH-1:0]   rdata0_d, rdata1_d;
  logic [G_REGWIDTH-1:0]   xfer_rdata;
  logic                    xfer_err;
  logic                    sel_write;

  assign m_apb_pprot = 3'b000;

  // Sole requester wins; on contention the one not served last wins.
  assign grant_sel   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign sel_write   = grant_sel ? req1_write : req0_write;
  assign timeout_hit = (G_TIMEOUT != 0) && !m_apb_pready && (cnt == CNT_W'(TMO_LAST));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_apb_pready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output, derived from the upcoming state.
  always_comb begin
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = m_apb_pwrite;
    paddr_d      = m_apb_paddr;
    pwdata_d     = m_apb_pwdata;
    pstrb_d      = m_apb_pstrb;
    grant_d      = grant;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = req0_rdata;
    rdata1_d     = req1_rdata;
    err0_d       = req0_err;
    err1_d       = req1_err;
    xfer_rdata   = (m_apb_pready && !m_apb_pwrite) ? m_apb_prdata : '0;
    xfer_err     = m_apb_pready ? m_apb_pslverr : 1'b1;

    case (state_nxt)
      SETUP:   psel_d = 1'b1;
      ACCESS:  begin psel_d = 1'b1; penable_d = 1'b1; end
      default: ;
    endcase

    if (state == IDLE && state_nxt == SETUP) begin
      grant_d  = grant_sel;
      pwrite_d = sel_write;
      paddr_d  = grant_sel ? req1_addr  : req0_addr;
      pwdata_d = grant_sel ? req1_wdata : req0_wdata;
      pstrb_d  = sel_write ? (grant_sel ? req1_strb : req0_strb) : '0;
    end

    if (state == ACCESS) begin
      if (state_nxt == ACCESS) begin
        cnt_d = cnt + CNT_W'(1);
      end else if (grant) begin
        done1_d  = 1'b1;
        rdata1_d = xfer_rdata;
        err1_d   = xfer_err;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = xfer_rdata;
        err0_d   = xfer_err;
      end
    end

    if (state == DONE) begin
      last_grant_d = grant;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      req0_rdata    <= '0;
      req1_rdata    <= '0;
      req0_err      <= 1'b0;
      req1_err      <= 1'b0;
    end else begin
      m_apb_psel    <= psel_d;
      m_apb_penable <= penable_d;
      m_apb_pwrite  <= pwrite_d;
      m_apb_paddr   <= paddr_d;
      m_apb_pwdata  <= pwdata_d;
      m_apb_pstrb   <= pstrb_d;
      grant         <= grant_d;
      last_grant    <= last_grant_d;
      cnt           <= cnt_d;
      req0_done     <= done0_d;
      req1_done     <= done1_d;
      req0_rdata    <= rdata0_d;
      req1_rdata    <= rdata1_d;
      req0_err      <= err0_d;
      req1_err      <= err1_d;
    end
  end

endmodule

// File: tb/tb_apb_arbiter2.sv
// Bench for apb_arbiter2: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and results.
module tb_apb_arbiter2;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 4;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 16;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic [SW-1:0] req0_strb = '0;
  logic          req0_done, req0_err;
  logic [DW-1:0] req0_rdata;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic [SW-1:0] req1_strb = '0;
  logic          req1_done, req1_err;
  logic [DW-1:0] req1_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [2:0]    pprot;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;

  apb_arbiter2 #(.G_REGWIDTH(DW), .G_ADDR_WIDTH(AW), .G_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
    .m_apb_pprot(pprot), .m_apb_paddr(paddr), .m_apb_pwdata(pwdata),
    .m_apb_pstrb(pstrb), .m_apb_pready(pready), .m_apb_prdata(prdata),
    .m_apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Slave: inserts slv_wait wait states per ACCESS, then answers.
  int            slv_wait = 0;
  logic          slv_err  = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt = 0;
  assign pready  = penable && (acc_cnt >= slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err && pready;

  always @(posedge clk) begin
    if (rst || !penable) acc_cnt <= 0;
    else if (!pready)    acc_cnt <= acc_cnt + 1;
  end

  // Requesters: hold the head command until its done, then move on.
  cmd_t q0[$], q1[$];
  always @(negedge clk) begin
    if (req0_done && q0.size() != 0) void'(q0.pop_front());
    if (req1_done && q1.size() != 0) void'(q1.pop_front());
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (req0_valid) begin
      req0_write = q0[0].wr; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata; req0_strb = q0[0].strb;
    end
    if (req1_valid) begin
      req1_write = q1[0].wr; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata; req1_strb = q1[0].strb;
    end
  end

  // Reference model: tracks elapsed cycles since grant and the winner's result.
  int            m_t = 0;           // 0 idle, 1 setup cycle, k>=2 is ACCESS cycle k-1, -1 done cycle
  int            m_last = 1, m_win = 0, m_acc_last = 0;
  cmd_t          m_cmd;
  int            grant_log[$];
  logic          started = 1'b0;
  logic          e_psel = 0, e_pen = 0;
  logic          e_done[2] = '{0, 0};
  logic          e_err[2]  = '{0, 0};
  logic [DW-1:0] e_rdata[2] = '{0, 0};

  task automatic m_finish(input logic [DW-1:0] rd, input logic er, input int nacc);
    e_psel = 0; e_pen = 0;
    e_done[m_win] = 1; e_rdata[m_win] = rd; e_err[m_win] = er;
    m_last = m_win; m_acc_last = nacc; m_t = -1;
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_t = 0; m_last = 1; e_psel = 0; e_pen = 0;
      e_done = '{0, 0}; e_err = '{0, 0}; e_rdata = '{0, 0};
    end else begin
      e_done = '{0, 0};
      if (m_t == -1) m_t = 0;
      else if (m_t == 0) begin
        if (req0_valid || req1_valid) begin
          m_win = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
          m_cmd.wr    = m_win ? req1_write : req0_write;
          m_cmd.addr  = m_win ? req1_addr  : req0_addr;
          m_cmd.wdata = m_win ? req1_wdata : req0_wdata;
          m_cmd.strb  = m_win ? req1_strb  : req0_strb;
          grant_log.push_back(m_win);
          m_t = 1; e_psel = 1; e_pen = 0;
        end
      end else if (m_t == 1) begin
        m_t = 2; e_pen = 1;
      end else begin
        if (pready)                      m_finish(m_cmd.wr ? '0 : prdata, pslverr, m_t - 1);
        else if (TMO != 0 && m_t - 1 == int'(TMO)) m_finish('0, 1'b1, m_t - 1);
        else                             m_t++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("psel", psel, e_psel);
      chk("penable", penable, e_pen);
      chk("pprot", pprot, 3'b000);
      chk("req0_done", req0_done, e_done[0]);
      chk("req1_done", req1_done, e_done[1]);
      chk("req0_rdata", req0_rdata, e_rdata[0]);
      chk("req1_rdata", req1_rdata, e_rdata[1]);
      chk("req0_err", req0_err, e_err[0]);
      chk("req1_err", req1_err, e_err[1]);
      if (e_psel) begin
        chk("pwrite", pwrite, m_cmd.wr);
        chk("paddr", paddr, m_cmd.addr);
        chk("pwdata", pwdata, m_cmd.wdata);
        chk("pstrb", pstrb, m_cmd.wr ? m_cmd.strb : '0);
      end
    end
  end

  task automatic push(input int port, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.strb = s;
    if (port == 0) q0.push_back(c);
    else           q1.push_back(c);
  endtask

  // Counts negedges from now until the port's done is seen (first negedge = 1).
  task automatic wait_done(input int port, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((port == 0) ? req0_done : req1_done) break;
      if (n >= budget) begin
        n_chk++;
        $display("FAIL wait_done%0d: no done within %0d cycles", port, budget);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_order[6];
    exp_order = '{0, 1, 0, 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_paddr", paddr, '0);
    chk("rst_pwdata", pwdata, '0);
    chk("rst_pstrb", pstrb, '0);
    chk("rst_rdata0", req0_rdata, '0);
    rst = 1'b0;

    // Zero-wait read by req0.
    slv_rdata = 32'hDEADBEEF;
    @(posedge clk); #2 push(0, 1'b0, 4'h4, 32'h0, 4'hF);
    wait_done(0, 20, n);
    chk("t1_latency", n, 4);
    chk("t1_rdata", req0_rdata, 32'hDEADBEEF);
    chk("t1_err", req0_err, 1'b0);

    // Write with three wait states by req1.
    slv_wait = 3;
    @(posedge clk); #2 push(1, 1'b1, 4'h8, 32'h12345678, 4'hF);
    wait_done(1, 30, n);
    chk("t2_latency", n, 7);
    chk("t2_err", req1_err, 1'b0);
    chk("t2_rdata", req1_rdata, 32'h0);

    // Hung slave: timeout after 16 ACCESS cycles.
    slv_wait = 1000; slv_rdata = 32'h55AA55AA;
    @(posedge clk); #2 push(0, 1'b0, 4'h2, 32'h0, 4'h0);
    wait_done(0, 40, n);
    chk("t3_latency", n, 19);
    chk("t3_acc_cycles", m_acc_last, 16);
    chk("t3_err", req0_err, 1'b1);
    chk("t3_rdata", req0_rdata, 32'h0);
    chk("t3_psel", psel, 1'b0);

    // Slave error on a read still captures data.
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'hCAFEF00D;
    @(posedge clk); #2 push(1, 1'b0, 4'h3, 32'h0, 4'hF);
    wait_done(1, 20, n);
    chk("t4_latency", n, 5);
    chk("t4_err", req1_err, 1'b1);
    chk("t4_rdata", req1_rdata, 32'hCAFEF00D);

    // Contention from reset: alternating grants.
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0BADF00D;
    rst = 1'b1;
    @(posedge clk); #2 grant_log.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      push(0, i[0], AW'(i + 1), 32'hA0000000 + DW'(i), 4'h3);
      push(1, ~i[0], AW'(i + 9), 32'hB0000000 + DW'(i), 4'hC);
    end
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 80) begin
      @(negedge clk); n++;
    end
    chk("t5_all_done", (q0.size() + q1.size()), 0);
    chk("t5_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("t5_grant%0d", i), grant_log[i], exp_order[i]);

    // Reset during ACCESS aborts without done; req0 then wins contention.
    slv_wait = 5;
    @(posedge clk); #2 push(1, 1'b0, 4'h5, 32'h0, 4'hF);
    n = 0;
    do begin @(negedge clk); n++; end while (!penable && n < 20);
    chk("t6_in_access", penable, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2;
    q0.delete(); q1.delete();
    chk("t6_psel", psel, 1'b0);
    chk("t6_penable", penable, 1'b0);
    chk("t6_nodone", req1_done, 1'b0);
    @(negedge clk); rst = 1'b0;
    slv_wait = 0;
    @(posedge clk); #2;
    push(0, 1'b0, 4'h6, 32'h0, 4'hF);
    push(1, 1'b0, 4'h7, 32'h0, 4'hF);
    wait_done(0, 20, n);
    chk("t6_req0_first", n, 4);
    wait_done(1, 20, n);
    chk("t6_req1_next", n, 4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
